lap_controller: RTL and testbench

Race-timing controller for the game phase. It sequences each lap from finish-line crossing to finish-line crossing, enforces in-order checkpoint passage, runs the lap clock, and detects over-long laps. It sits between the track-collision logic (checkpoint and finish strobes) and `main_fsm`, driving `main_fsm`'s `lap_finished`, `checkpoints_passed` and `max_lap_time_exceeded` inputs plus the lap-time values used by the HUD.

---
 rtl/lap_controller.sv | 182 ++++++++++++++++++
 tb/tb_lap_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lap_controller.sv
// ============================================================================
// Module      : lap_controller
// Description : Lap sequencer. It enforces in-order checkpoints, runs the lap
//               clock and detects lap timeouts. Defining LAP_BEST_TRACK_EN
//               enables best-lap tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lap_controller #(
  parameter int TICK_DIV      = 650000,
  parameter int N_CP          = 4,
  parameter int MAX_LAP_TICKS = 6000
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            game_active,
  input  logic            finish_hit,
  input  logic [N_CP-1:0] cp_hit,
  output logic            lap_finished,
  output logic            checkpoints_passed,
  output logic            max_lap_time_exceeded,
  output logic [13:0]     lap_time,
  output logic [13:0]     last_lap,
  output logic [7:0]      lap_count,
  output logic [13:0]     best_lap
);

  localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [13:0] LAP_MAX  = 14'(MAX_LAP_TICKS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [13:0]     lap_time_q, lap_time_d;
  logic [N_CP-1:0] mask_q, mask_d;
  logic [13:0]     last_lap_q, last_lap_d;
  logic [7:0]      lap_count_q, lap_count_d;
  logic            lap_finished_q, lap_finished_d;
  logic            cp_passed_q, cp_passed_d;
  logic            timeout_q, timeout_d;
  logic            valid_finish;
  logic            prefix_ok;
  logic [N_CP-1:0] cp_accept;

  // A checkpoint counts only when every lower-numbered one is already held.
  always_comb begin
    cp_accept = '0;
    prefix_ok = 1'b1;
    for (int i = 0; i < N_CP; i++) begin
      cp_accept[i] = cp_hit[i] & prefix_ok;
      prefix_ok    = prefix_ok & mask_q[i];
    end
  end

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    lap_time_d     = lap_time_q;
    mask_d         = mask_q;
    last_lap_d     = last_lap_q;
    lap_count_d    = lap_count_q;
    lap_finished_d = 1'b0;
    timeout_d      = 1'b0;
    valid_finish   = 1'b0;

    if (!game_active) begin
      state_d    = IDLE;
      presc_d    = '0;
      lap_time_d = '0;
      mask_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d    = '0;
          lap_time_d = '0;
          mask_d     = '0;
          state_d    = ARMED;
        end
        ARMED: begin
          lap_time_d = '0;
          if (finish_hit) begin
            state_d = RUNNING;
            mask_d  = '0;
            presc_d = '0;
          end
        end
        RUNNING: begin
          if (finish_hit) begin
            // Finish takes priority over both checkpoint hits and a timeout tick.
            lap_finished_d = 1'b1;
            valid_finish   = &mask_q;
            if (valid_finish) begin
              last_lap_d  = lap_time_q;
              lap_count_d = lap_count_q + 8'd1;
            end
            mask_d     = '0;
            lap_time_d = '0;
            presc_d    = '0;
          end else begin
            mask_d = mask_q | cp_accept;
            if (presc_q == PRESC_TOP) begin
              presc_d = '0;
              if (lap_time_q + 14'd1 == LAP_MAX) begin
                timeout_d  = 1'b1;
                mask_d     = '0;
                lap_time_d = '0;
                state_d    = ARMED;
              end else begin
                lap_time_d = lap_time_q + 14'd1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    cp_passed_d = lap_finished_d ? (&mask_q) : (&mask_d);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      lap_time_q     <= '0;
      mask_q         <= '0;
      last_lap_q     <= '0;
      lap_count_q    <= '0;
      lap_finished_q <= 1'b0;
      cp_passed_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      lap_time_q     <= lap_time_d;
      mask_q         <= mask_d;
      last_lap_q     <= last_lap_d;
      lap_count_q    <= lap_count_d;
      lap_finished_q <= lap_finished_d;
      cp_passed_q    <= cp_passed_d;
      timeout_q      <= timeout_d;
    end
  end

`ifdef LAP_BEST_TRACK_EN
  logic [13:0] best_lap_q, best_lap_d;

  // Strict compare: a tie keeps the earlier record.
  always_comb begin
    best_lap_d = best_lap_q;
    if (valid_finish && (lap_time_q < best_lap_q)) best_lap_d = lap_time_q;
  end

  always_ff @(posedge pclk) begin
    if (rst) best_lap_q <= 14'h3FFF;
    else     best_lap_q <= best_lap_d;
  end

  assign best_lap = best_lap_q;
`else
  assign best_lap = 14'h3FFF;
`endif

  assign lap_finished          = lap_finished_q;
  assign checkpoints_passed    = cp_passed_q;
  assign max_lap_time_exceeded = timeout_q;
  assign lap_time              = lap_time_q;
  assign last_lap              = last_lap_q;
  assign lap_count             = lap_count_q;

endmodule

`default_nettype wire

// File: tb/tb_lap_controller.sv
// ============================================================================
// Module      : tb_lap_controller
// Description : Directed self-checking bench for lap_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lap_controller;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        game_active = 1'b0;
  logic        finish_hit = 1'b0;
  logic [1:0]  cp_hit = 2'b00;
  logic        lap_finished;
  logic        checkpoints_passed;
  logic        max_lap_time_exceeded;
  logic [13:0] lap_time;
  logic [13:0] last_lap;
  logic [7:0]  lap_count;
  logic [13:0] best_lap;

  int checks = 0;
  int errors = 0;

`ifdef LAP_BEST_TRACK_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  lap_controller #(.TICK_DIV(4), .N_CP(2), .MAX_LAP_TICKS(10)) dut (
    .pclk                 (pclk),
    .rst                  (rst),
    .game_active          (game_active),
    .finish_hit           (finish_hit),
    .cp_hit               (cp_hit),
    .lap_finished         (lap_finished),
    .checkpoints_passed   (checkpoints_passed),
    .max_lap_time_exceeded(max_lap_time_exceeded),
    .lap_time             (lap_time),
    .last_lap             (last_lap),
    .lap_count            (lap_count),
    .best_lap             (best_lap)
  );

  always #5 pclk = ~pclk;

  // Apply one cycle of stimulus; outputs are then sampled 1 ns past the edge.
  task automatic step(input logic f, input logic [1:0] c);
    finish_hit = f;
    cp_hit     = c;
    @(posedge pclk);
    #1;
    finish_hit = 1'b0;
    cp_hit     = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00);
  endtask

  task automatic test_reset;
    rst = 1'b1; game_active = 1'b0;
    step(1'b0, 2'b00); step(1'b0, 2'b00);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL reset_lap_finished got %0h want 0", lap_finished); end
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL reset_cp_passed got %0h want 0", checkpoints_passed); end
    checks++; if (max_lap_time_exceeded !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0h want 0", max_lap_time_exceeded); end
    checks++; if (lap_time !== 14'd0) begin errors++; $display("FAIL reset_lap_time got %0d want 0", lap_time); end
    checks++; if (last_lap !== 14'd0) begin errors++; $display("FAIL reset_last_lap got %0d want 0", last_lap); end
    checks++; if (lap_count !== 8'd0) begin errors++; $display("FAIL reset_lap_count got %0d want 0", lap_count); end
    checks++; if (best_lap !== 14'h3FFF) begin errors++; $display("FAIL reset_best_lap got %0h want 3fff", best_lap); end
    rst = 1'b0; game_active = 1'b1;
    step(1'b0, 2'b00);
  endtask

  task automatic test_valid_lap;
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL armed_finish_no_pulse got %0h want 0", lap_finished); end
    idle(12);
    checks++; if (lap_time !== 14'd3) begin errors++; $display("FAIL valid_lap_time_run got %0d want 3", lap_time); end
    step(1'b0, 2'b01);
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL valid_cp_partial got %0h want 0", checkpoints_passed); end
    step(1'b0, 2'b10);
    checks++; if (checkpoints_passed !== 1'b1) begin errors++; $display("FAIL valid_cp_all got %0h want 1", checkpoints_passed); end
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b1) begin errors++; $display("FAIL valid_lap_finished got %0h want 1", lap_finished); end
    checks++; if (checkpoints_passed !== 1'b1) begin errors++; $display("FAIL valid_finish_cp got %0h want 1", checkpoints_passed); end
    checks++; if (last_lap !== 14'd3) begin errors++; $display("FAIL valid_last_lap got %0d want 3", last_lap); end
    checks++; if (lap_count !== 8'd1) begin errors++; $display("FAIL valid_lap_count got %0d want 1", lap_count); end
    checks++; if (lap_time !== 14'd0) begin errors++; $display("FAIL valid_lap_time_clear got %0d want 0", lap_time); end
    step(1'b0, 2'b00);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL valid_pulse_width got %0h want 0", lap_finished); end
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL valid_mask_cleared got %0h want 0", checkpoints_passed); end
  endtask

  task automatic test_out_of_order;
    step(1'b1, 2'b00);
    step(1'b0, 2'b10);
    step(1'b0, 2'b01);
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL ooo_cp got %0h want 0", checkpoints_passed); end
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b1) begin errors++; $display("FAIL ooo_lap_finished got %0h want 1", lap_finished); end
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL ooo_finish_cp got %0h want 0", checkpoints_passed); end
    checks++; if (lap_count !== 8'd1) begin errors++; $display("FAIL ooo_lap_count got %0d want 1", lap_count); end
    checks++; if (last_lap !== 14'd3) begin errors++; $display("FAIL ooo_last_lap got %0d want 3", last_lap); end
    // Checkpoint bit 0 on the finish cycle must be dropped.
    step(1'b1, 2'b01);
    step(1'b0, 2'b10);
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL cp_with_finish_ignored got %0h want 0", checkpoints_passed); end
  endtask

  task automatic test_timeout;
    step(1'b1, 2'b00);
    step(1'b0, 2'b01);
    step(1'b0, 2'b10);
    for (int i = 0; i < 37; i++) begin
      step(1'b0, 2'b00);
      checks++; if (max_lap_time_exceeded !== 1'b0) begin errors++; $display("FAIL timeout_early got %0h want 0 at %0d", max_lap_time_exceeded, i); end
    end
    checks++; if (lap_time !== 14'd9) begin errors++; $display("FAIL timeout_pre_lap_time got %0d want 9", lap_time); end
    step(1'b0, 2'b00);
    checks++; if (max_lap_time_exceeded !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %0h want 1", max_lap_time_exceeded); end
    checks++; if (lap_time !== 14'd0) begin errors++; $display("FAIL timeout_lap_time got %0d want 0", lap_time); end
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL timeout_mask got %0h want 0", checkpoints_passed); end
    idle(8);
    checks++; if (max_lap_time_exceeded !== 1'b0) begin errors++; $display("FAIL timeout_once got %0h want 0", max_lap_time_exceeded); end
    checks++; if (lap_time !== 14'd0) begin errors++; $display("FAIL armed_hold got %0d want 0", lap_time); end
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL rearm_no_pulse got %0h want 0", lap_finished); end
  endtask

  task automatic test_simultaneous;
    idle(39);
    checks++; if (lap_time !== 14'd9) begin errors++; $display("FAIL simul_pre_lap_time got %0d want 9", lap_time); end
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b1) begin errors++; $display("FAIL simul_lap_finished got %0h want 1", lap_finished); end
    checks++; if (max_lap_time_exceeded !== 1'b0) begin errors++; $display("FAIL simul_timeout got %0h want 0", max_lap_time_exceeded); end
    checks++; if (lap_count !== 8'd1) begin errors++; $display("FAIL simul_lap_count got %0d want 1", lap_count); end
    step(1'b0, 2'b00);
    checks++; if (max_lap_time_exceeded !== 1'b0) begin errors++; $display("FAIL simul_timeout_late got %0h want 0", max_lap_time_exceeded); end
  endtask

  task automatic run_lap(input int n, input logic [7:0] cnt, input logic [13:0] best);
    step(1'b0, 2'b01);
    step(1'b0, 2'b10);
    idle(4 * n - 2);
    step(1'b1, 2'b00);
    checks++; if (last_lap !== 14'(n)) begin errors++; $display("FAIL best_last_lap got %0d want %0d", last_lap, n); end
    checks++; if (lap_count !== cnt) begin errors++; $display("FAIL best_lap_count got %0d want %0d", lap_count, cnt); end
    checks++; if (best_lap !== best) begin errors++; $display("FAIL best_lap_value got %0h want %0h", best_lap, best); end
  endtask

  task automatic test_best_lap;
    rst = 1'b1; step(1'b0, 2'b00);
    rst = 1'b0; step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    run_lap(6, 8'd1, BEST_EN ? 14'd6 : 14'h3FFF);
    run_lap(4, 8'd2, BEST_EN ? 14'd4 : 14'h3FFF);
    run_lap(4, 8'd3, BEST_EN ? 14'd4 : 14'h3FFF);
  endtask

  task automatic test_exit_reset;
    idle(6);
    checks++; if (lap_time !== 14'd1) begin errors++; $display("FAIL exit_pre_lap_time got %0d want 1", lap_time); end
    game_active = 1'b0;
    step(1'b0, 2'b00);
    checks++; if (lap_time !== 14'd0) begin errors++; $display("FAIL exit_lap_time got %0d want 0", lap_time); end
    checks++; if (lap_count !== 8'd3) begin errors++; $display("FAIL exit_lap_count got %0d want 3", lap_count); end
    checks++; if (last_lap !== 14'd4) begin errors++; $display("FAIL exit_last_lap got %0d want 4", last_lap); end
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL idle_finish_no_pulse got %0h want 0", lap_finished); end
    game_active = 1'b1;
    step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL reentry_no_pulse got %0h want 0", lap_finished); end
    idle(5);
    rst = 1'b1;
    step(1'b1, 2'b01);
    checks++; if (lap_finished !== 1'b0) begin errors++; $display("FAIL rst_lap_finished got %0h want 0", lap_finished); end
    checks++; if (lap_time !== 14'd0) begin errors++; $display("FAIL rst_lap_time got %0d want 0", lap_time); end
    checks++; if (lap_count !== 8'd0) begin errors++; $display("FAIL rst_lap_count got %0d want 0", lap_count); end
    checks++; if (last_lap !== 14'd0) begin errors++; $display("FAIL rst_last_lap got %0d want 0", last_lap); end
    checks++; if (best_lap !== 14'h3FFF) begin errors++; $display("FAIL rst_best_lap got %0h want 3fff", best_lap); end
    checks++; if (checkpoints_passed !== 1'b0) begin errors++; $display("FAIL rst_cp_passed got %0h want 0", checkpoints_passed); end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_valid_lap();
    test_out_of_order();
    test_timeout();
    test_simultaneous();
    test_best_lap();
    test_exit_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
